// File: rtl/temp_sample_ctrl.sv
// temp_sample_ctrl: temperature sensor sequencer.
//   Periodically requests a reading from the 8-bit sensor, averages 2**AVG_LOG2
//   readings, compares the average against high/low thresholds with hysteresis,
//   and raises a sticky interrupt on alarm entry or sensor timeout.
// Ports:
//   clk, reset         system clock (posedge), asynchronous active-low reset
//   enable             run sequencing; low returns to IDLE and drops the partial batch
//   sample_req         reading request, high while in REQ (decoded from state)
//   sensor_valid/temp  sensor response, accepted only in REQ
//   thresh_hi/lo       alarm thresholds, sampled in EVAL
//   avg_temp/avg_valid last average and its one-cycle update pulse
//   alarm_hi/lo        level alarms with hysteresis release
//   sensor_fault, irq  sticky fault / interrupt, both cleared by irq_ack
module temp_sample_ctrl #(
  parameter int unsigned INTERVAL = 100,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned HYST     = 4,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       sample_req,
  input  logic       sensor_valid,
  input  logic [7:0] sensor_temp,
  input  logic [7:0] thresh_hi,
  input  logic [7:0] thresh_lo,
  output logic [7:0] avg_temp,
  output logic       avg_valid,
  output logic       alarm_hi,
  output logic       alarm_lo,
  output logic       sensor_fault,
  output logic       irq,
  input  logic       irq_ack
);

  localparam int unsigned TEMP_W = 8;
  localparam int unsigned ACC_W  = TEMP_W + AVG_LOG2;
  localparam int unsigned CNT_W  = AVG_LOG2 + 1;
  localparam int unsigned WAIT_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam int unsigned TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CNT_W-1:0]  BATCH_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(INTERVAL - 1);
  localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(TIMEOUT - 1);
  localparam logic [TEMP_W:0]   HYST_EXT   = (TEMP_W + 1)'(HYST);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_REQ,
    S_EVAL
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                accept;
  logic                timeout_hit;
  logic                batch_done;
  logic                eval_fire;
  logic [TEMP_W-1:0]   avg;
  logic [TEMP_W:0]     hi_rel_raw;
  logic [TEMP_W:0]     lo_rel_raw;
  logic [TEMP_W-1:0]   hi_rel;
  logic [TEMP_W-1:0]   lo_rel;
  logic                hi_next;
  logic                lo_next;
  logic                irq_rise;

  // Request is a pure state decode so it falls with the state on reset or disable.
  assign sample_req = (state_q == S_REQ);

  // Next-state, counter, accumulator and alarm evaluation.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = '0;
    to_cnt_d    = '0;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    accept      = 1'b0;
    timeout_hit = 1'b0;
    batch_done  = 1'b0;
    eval_fire   = 1'b0;
    hi_next     = alarm_hi;
    lo_next     = alarm_lo;
    irq_rise    = 1'b0;

    accept      = enable && (state_q == S_REQ) && sensor_valid;
    timeout_hit = enable && (state_q == S_REQ) && !sensor_valid && (to_cnt_q == TO_LAST);
    batch_done  = accept && (cnt_q == BATCH_LAST);
    eval_fire   = enable && (state_q == S_EVAL);

    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_WAIT;
        S_WAIT: if (wait_cnt_q == WAIT_LAST) state_d = S_REQ;
        S_REQ: begin
          if (accept)           state_d = batch_done ? S_EVAL : S_WAIT;
          else if (timeout_hit) state_d = S_WAIT;
        end
        S_EVAL: state_d = S_WAIT;
        default: state_d = S_IDLE;
      endcase
    end

    // Dwell counters restart whenever their state is (re)entered.
    if (state_q == S_WAIT && state_d == S_WAIT) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    if (state_q == S_REQ && state_d == S_REQ)   to_cnt_d   = to_cnt_q + TO_W'(1);

    // A batch is dropped on disable or timeout and consumed by EVAL.
    if (!enable || timeout_hit || state_q == S_EVAL) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      acc_d = acc_q + ACC_W'(sensor_temp);
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Hysteresis release points, clamped to the 8-bit range.
    hi_rel_raw = {1'b0, thresh_hi} - HYST_EXT;
    lo_rel_raw = {1'b0, thresh_lo} + HYST_EXT;
    hi_rel     = hi_rel_raw[TEMP_W] ? '0 : hi_rel_raw[TEMP_W-1:0];
    lo_rel     = lo_rel_raw[TEMP_W] ? '1 : lo_rel_raw[TEMP_W-1:0];

    avg = TEMP_W'(acc_q >> AVG_LOG2);

    if (avg > thresh_hi)   hi_next = 1'b1;
    else if (avg < hi_rel) hi_next = 1'b0;

    if (avg < thresh_lo)   lo_next = 1'b1;
    else if (avg > lo_rel) lo_next = 1'b0;

    irq_rise = (eval_fire && ((hi_next && !alarm_hi) || (lo_next && !alarm_lo))) ||
               (timeout_hit && !sensor_fault);
  end

  // State, counters and accumulator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      to_cnt_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      to_cnt_q   <= to_cnt_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
    end
  end

  // Registered results; a new interrupt source wins over a same-cycle ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      avg_temp     <= '0;
      avg_valid    <= 1'b0;
      alarm_hi     <= 1'b0;
      alarm_lo     <= 1'b0;
      sensor_fault <= 1'b0;
      irq          <= 1'b0;
    end else begin
      avg_valid    <= eval_fire;
      if (eval_fire) begin
        avg_temp <= avg;
        alarm_hi <= hi_next;
        alarm_lo <= lo_next;
      end
      sensor_fault <= timeout_hit || (sensor_fault && !irq_ack);
      irq          <= irq_rise || (irq && !irq_ack);
    end
  end

endmodule

// File: tb/tb_temp_sample_ctrl.sv
// tb_temp_sample_ctrl: directed bench for temp_sample_ctrl (INTERVAL=3, AVG_LOG2=2,
// HYST=4, TIMEOUT=16). A table of hand-computed batches plus sequences for timeout,
// disable, ack collision and asynchronous reset.
module tb_temp_sample_ctrl;

  localparam int unsigned INTERVAL = 3;
  localparam int unsigned AVG_LOG2 = 2;
  localparam int unsigned HYST     = 4;
  localparam int unsigned TIMEOUT  = 16;
  localparam int          PERIOD   = INTERVAL + 1;
  localparam int          NROWS    = 14;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       sample_req;
  logic       sensor_valid;
  logic [7:0] sensor_temp;
  logic [7:0] thresh_hi;
  logic [7:0] thresh_lo;
  logic [7:0] avg_temp;
  logic       avg_valid;
  logic       alarm_hi;
  logic       alarm_lo;
  logic       sensor_fault;
  logic       irq;
  logic       irq_ack;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  temp_sample_ctrl #(
    .INTERVAL(INTERVAL),
    .AVG_LOG2(AVG_LOG2),
    .HYST    (HYST),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .sample_req  (sample_req),
    .sensor_valid(sensor_valid),
    .sensor_temp (sensor_temp),
    .thresh_hi   (thresh_hi),
    .thresh_lo   (thresh_lo),
    .avg_temp    (avg_temp),
    .avg_valid   (avg_valid),
    .alarm_hi    (alarm_hi),
    .alarm_lo    (alarm_lo),
    .sensor_fault(sensor_fault),
    .irq         (irq),
    .irq_ack     (irq_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] s0, s1, s2, s3;
    logic [7:0] thi, tlo;
    logic       ack_before;
    logic       ack_eval;
    logic [7:0] avg;
    logic       hi, lo, irq;
  } vec_t;

  vec_t tbl [NROWS];

  function automatic vec_t mk(input int s0, input int s1, input int s2, input int s3,
                              input int thi, input int tlo, input bit ab, input bit ae,
                              input int avg, input bit hi, input bit lo, input bit iq);
    vec_t v;
    v.s0 = 8'(s0); v.s1 = 8'(s1); v.s2 = 8'(s2); v.s3 = 8'(s3);
    v.thi = 8'(thi); v.tlo = 8'(tlo);
    v.ack_before = ab; v.ack_eval = ae;
    v.avg = 8'(avg); v.hi = hi; v.lo = lo; v.irq = iq;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Poll (at edge+1) until sample_req is high, bounded.
  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (sample_req) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL wait_req: got no sample_req expected one within 64 cycles");
    end
  endtask

  // Answer the next request with one reading; t is the cycle the request was seen.
  task automatic feed(input logic [7:0] v, output int t);
    bit got;
    wait_req(got);
    t = cyc;
    if (got) begin
      sensor_valid = 1'b1;
      sensor_temp  = v;
      @(posedge clk); #1;
      sensor_valid = 1'b0;
    end
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1;
    @(posedge clk); #1;
    irq_ack = 1'b0;
  endtask

  // Feed four readings, then step past EVAL; leaves us in the avg_valid cycle.
  task automatic run_batch(input int row, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d, input bit ack_eval);
    logic [7:0] sv [4];
    int t, tprev;
    sv[0] = a; sv[1] = b; sv[2] = c; sv[3] = d;
    tprev = 0;
    for (int i = 0; i < 4; i++) begin
      feed(sv[i], t);
      if (i > 0) chk($sformatf("row%0d_req_gap%0d", row, i), t - tprev, PERIOD);
      tprev = t;
    end
    if (ack_eval) irq_ack = 1'b1;
    @(posedge clk); #1;
    irq_ack = 1'b0;
    chk($sformatf("row%0d_avg_valid", row), int'(avg_valid), 1);
  endtask

  task automatic check_result(input int row, input int avg, input bit hi, input bit lo,
                              input bit iq);
    chk($sformatf("row%0d_avg_temp", row), int'(avg_temp), avg);
    chk($sformatf("row%0d_alarm_hi", row), int'(alarm_hi), int'(hi));
    chk($sformatf("row%0d_alarm_lo", row), int'(alarm_lo), int'(lo));
    chk($sformatf("row%0d_irq", row), int'(irq), int'(iq));
    @(posedge clk); #1;
    chk($sformatf("row%0d_avg_valid_drop", row), int'(avg_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  t;
    int  n;
    bit  got;

    reset        = 1'b0;
    enable       = 1'b0;
    sensor_valid = 1'b0;
    sensor_temp  = '0;
    thresh_hi    = '0;
    thresh_lo    = '0;
    irq_ack      = 1'b0;

    //            samples           thi  tlo ab ae avg  hi lo irq
    tbl[0]  = mk( 10,  20,  30,  41, 100, 20, 0, 0,  25, 0, 0, 0);
    tbl[1]  = mk(101, 101, 101, 101, 100, 20, 0, 0, 101, 1, 0, 1);
    tbl[2]  = mk( 97,  97,  97,  98, 100, 20, 0, 0,  97, 1, 0, 1);
    tbl[3]  = mk( 95,  95,  95,  95, 100, 20, 0, 0,  95, 0, 0, 1);
    tbl[4]  = mk( 19,  19,  19,  19, 100, 20, 1, 1,  19, 0, 1, 1);
    tbl[5]  = mk( 23,  23,  23,  23, 100, 20, 0, 0,  23, 0, 1, 1);
    tbl[6]  = mk( 25,  25,  25,  25, 100, 20, 0, 0,  25, 0, 0, 1);
    tbl[7]  = mk( 55,  55,  55,  55,  50, 60, 0, 0,  55, 1, 1, 1);
    tbl[8]  = mk( 30,  30,  30,  30, 200,  0, 1, 0,  30, 0, 0, 0);
    tbl[9]  = mk(  0,   0,   0,   3, 200,  0, 0, 0,   0, 0, 0, 0);
    tbl[10] = mk(  3,   3,   3,   3,   2,  0, 0, 0,   3, 1, 0, 1);
    tbl[11] = mk(  0,   0,   0,   0,   2,  0, 0, 0,   0, 1, 0, 1);
    tbl[12] = mk(254, 254, 254, 254, 255, 255, 0, 0, 254, 1, 1, 1);
    tbl[13] = mk(255, 255, 255, 255, 255, 255, 0, 0, 255, 1, 1, 1);

    #12;
    chk("reset_outputs", int'({sample_req, avg_temp, avg_valid, alarm_hi, alarm_lo,
                               sensor_fault, irq}), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    enable = 1'b1;

    for (int r = 0; r < NROWS; r++) begin
      thresh_hi = tbl[r].thi;
      thresh_lo = tbl[r].tlo;
      if (tbl[r].ack_before) begin
        pulse_ack();
        chk($sformatf("row%0d_ack_clears_irq", r), int'(irq), 0);
      end
      run_batch(r, tbl[r].s0, tbl[r].s1, tbl[r].s2, tbl[r].s3, tbl[r].ack_eval);
      check_result(r, int'(tbl[r].avg), tbl[r].hi, tbl[r].lo, tbl[r].irq);
    end

    // Sensor timeout: partial batch of two 200s must be discarded.
    pulse_ack();
    chk("pre_timeout_irq", int'(irq), 0);
    chk("pre_timeout_fault", int'(sensor_fault), 0);
    thresh_hi = 8'd200;
    thresh_lo = 8'd0;
    feed(8'd200, t);
    feed(8'd200, t);
    wait_req(got);
    n = 0;
    while (sample_req && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    chk("timeout_req_cycles", n, TIMEOUT);
    chk("timeout_fault", int'(sensor_fault), 1);
    chk("timeout_irq", int'(irq), 1);
    run_batch(100, 8'd40, 8'd40, 8'd40, 8'd40, 1'b0);
    check_result(100, 40, 0, 0, 1);
    chk("fault_sticky", int'(sensor_fault), 1);
    pulse_ack();
    chk("ack_clears_irq", int'(irq), 0);
    chk("ack_clears_fault", int'(sensor_fault), 0);

    // Disable after two of four samples; outputs hold, next batch is fresh.
    feed(8'd200, t);
    feed(8'd200, t);
    wait_req(got);
    enable = 1'b0;
    @(posedge clk); #1;
    chk("disable_req_drop", int'(sample_req), 0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("disable_req_idle", int'(sample_req), 0);
    chk("disable_avg_hold", int'(avg_temp), 40);
    chk("disable_avg_valid", int'(avg_valid), 0);
    chk("disable_alarms_hold", int'({alarm_hi, alarm_lo}), 0);
    chk("disable_irq_hold", int'(irq), 0);
    thresh_hi = 8'd50;
    enable    = 1'b1;
    run_batch(101, 8'd60, 8'd60, 8'd60, 8'd60, 1'b0);
    check_result(101, 60, 1, 0, 1);

    // Asynchronous reset in the middle of a REQ cycle.
    feed(8'd90, t);
    wait_req(got);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_outputs", int'({sample_req, avg_temp, avg_valid, alarm_hi, alarm_lo,
                                     sensor_fault, irq}), 0);
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
    thresh_hi = 8'd200;
    thresh_lo = 8'd0;
    run_batch(102, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    check_result(102, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
